mastermind_core: RTL and testbench

Parametrised game engine for the guess-the-code game on the DE-board top level. It supports N digits, a configurable digit range and a configurable number of chances. Each target digit can be set manually or from the LFSR. After each guess it reports full Mastermind scoring: exact hits and misplaced hits. It sits between the debouncers/priority encoder/LFSR and the display controller, and absorbs the blink divider that previously lived in the top level.

---
 rtl/game_types_pkg.sv | 25 ++
 rtl/mastermind_core_if.sv | 18 +
 rtl/mastermind_scorer.sv | 84 ++++++++
 rtl/mastermind_core.sv | 176 +++++++++++++++++
 tb/tb_mastermind_core.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_types_pkg.sv
// game_types: shared types for the guess-the-code game.
//   digit_t  - one code digit (0..15 encoding, legal range set by DIGIT_MAX)
//   state_t  - game FSM states
//   fold_digit - maps a random nibble into 0..max
package game_types;

   typedef logic [3:0] digit_t;

   typedef enum logic [2:0] {
      S_SET_TARGET = 3'd0,
      S_GUESS      = 3'd1,
      S_SCORE      = 3'd2,
      S_WIN        = 3'd3,
      S_LOSE       = 3'd4
   } state_t;

   // A random nibble above max wraps down by (max+1). max >= 7 means a
   // single subtraction always lands inside the legal range.
   function automatic digit_t fold_digit(input digit_t raw, input digit_t max);
      logic [4:0] lim;
      lim = {1'b0, max} + 5'd1;
      return (raw <= max) ? raw : digit_t'({1'b0, raw} - lim);
   endfunction

endpackage

// File: rtl/mastermind_core_if.sv
// mastermind_core_if: player input bundle feeding the game engine.
//   set_pulse - one-cycle confirm pulse
//   alt_pulse - one-cycle alternate pulse (random digit / backspace)
//   sw_val    - encoded switch value, meaningful when sw_valid = 1
//   lfsr_val  - free-running random nibble
// master drives the bundle, slave (the engine) consumes it.
interface mastermind_core_if;
   import game_types::*;

   logic   set_pulse;
   logic   alt_pulse;
   digit_t sw_val;
   logic   sw_valid;
   digit_t lfsr_val;

   modport master (output set_pulse, alt_pulse, sw_val, sw_valid, lfsr_val);
   modport slave  (input  set_pulse, alt_pulse, sw_val, sw_valid, lfsr_val);
endinterface

// File: rtl/mastermind_scorer.sv
// mastermind_scorer: sequential Mastermind scoring.
//   clk, reset_n    - clock, async active-low reset
//   start           - one-cycle pulse, digits must be stable from then on
//   target, guess   - registered code and guess digits
//   done            - one-cycle pulse DIGIT_MAX+1 cycles after start
//   exact, part     - score, valid while done is high
// Sweeps v = 0..DIGIT_MAX, summing min(count of v in target, count of v
// in guess); that total minus the exact matches gives the misplaced hits.
module mastermind_scorer
   import game_types::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIGIT_MAX  = 9
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              start,
   input  digit_t [NUM_DIGITS-1:0]           target,
   input  digit_t [NUM_DIGITS-1:0]           guess,
   output logic                              done,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   exact,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   part
);
   localparam int CW = $clog2(NUM_DIGITS+1);

   digit_t        v_r;
   logic          busy_r;
   logic [CW-1:0] acc_r;
   logic          done_r;
   logic [CW-1:0] exact_r;
   logic [CW-1:0] part_r;

   logic [CW-1:0] cnt_t_s;
   logic [CW-1:0] cnt_g_s;
   logic [CW-1:0] min_s;
   logic [CW-1:0] exact_s;

   // Per-value occurrence counts, their minimum and the positional matches.
   always_comb begin
      cnt_t_s = '0;
      cnt_g_s = '0;
      exact_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         cnt_t_s = cnt_t_s + ((target[i] == v_r)      ? CW'(1) : CW'(0));
         cnt_g_s = cnt_g_s + ((guess[i]  == v_r)      ? CW'(1) : CW'(0));
         exact_s = exact_s + ((guess[i]  == target[i]) ? CW'(1) : CW'(0));
      end
      min_s = (cnt_t_s < cnt_g_s) ? cnt_t_s : cnt_g_s;
   end

   // Value sweep: start consumes v = 0, the last value produces done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_r     <= 4'd0;
         busy_r  <= 1'b0;
         acc_r   <= '0;
         done_r  <= 1'b0;
         exact_r <= '0;
         part_r  <= '0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            acc_r  <= min_s;
            v_r    <= 4'd1;
            busy_r <= 1'b1;
         end else if (busy_r) begin
            if (v_r == 4'(DIGIT_MAX)) begin
               done_r  <= 1'b1;
               exact_r <= exact_s;
               part_r  <= acc_r + min_s - exact_s;
               busy_r  <= 1'b0;
               v_r     <= 4'd0;
            end else begin
               acc_r <= acc_r + min_s;
               v_r   <= v_r + 4'd1;
            end
         end
      end
   end

   assign done  = done_r;
   assign exact = exact_r;
   assign part  = part_r;
endmodule

// File: rtl/mastermind_core.sv
// mastermind_core: guess-the-code game engine.
//   CLOCK_50, reset_n     - clock, async active-low reset
//   bus (slave)           - set/alt pulses, switch value, LFSR nibble
//   state                 - FSM state
//   target, guess         - secret code and current guess
//   is_random             - per-digit flag, digit came from the LFSR
//   cursor                - digit being entered
//   chances               - guesses remaining
//   exact_cnt, part_cnt   - last score
//   blink_on              - square wave toggling every BLINK_DIV cycles
module mastermind_core
   import game_types::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DIGIT_MAX   = 9,
   parameter int MAX_CHANCES = 5,
   parameter int BLINK_DIV   = 25_000_000
) (
   input  logic                                CLOCK_50,
   input  logic                                reset_n,
   mastermind_core_if.slave                    bus,
   output state_t                              state,
   output digit_t [NUM_DIGITS-1:0]             target,
   output digit_t [NUM_DIGITS-1:0]             guess,
   output logic [NUM_DIGITS-1:0]               is_random,
   output logic [$clog2(NUM_DIGITS)-1:0]       cursor,
   output logic [$clog2(MAX_CHANCES+1)-1:0]    chances,
   output logic [$clog2(NUM_DIGITS+1)-1:0]     exact_cnt,
   output logic [$clog2(NUM_DIGITS+1)-1:0]     part_cnt,
   output logic                                blink_on
);
   localparam int CUR_W = $clog2(NUM_DIGITS);
   localparam int CH_W  = $clog2(MAX_CHANCES+1);
   localparam int CNT_W = $clog2(NUM_DIGITS+1);
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   state_t                  state_r;
   digit_t [NUM_DIGITS-1:0] target_r;
   digit_t [NUM_DIGITS-1:0] guess_r;
   logic [NUM_DIGITS-1:0]   is_random_r;
   logic [CUR_W-1:0]        cursor_r;
   logic [CH_W-1:0]         chances_r;
   logic [CNT_W-1:0]        exact_cnt_r;
   logic [CNT_W-1:0]        part_cnt_r;
   logic                    start_r;
   logic [BLK_W-1:0]        blink_cnt_r;
   logic                    blink_r;

   logic                    accept_s;
   logic                    last_s;
   logic                    done_s;
   logic [CNT_W-1:0]        exact_s;
   logic [CNT_W-1:0]        part_s;

   assign accept_s = bus.set_pulse && bus.sw_valid && (bus.sw_val <= 4'(DIGIT_MAX));
   assign last_s   = (cursor_r == CUR_W'(NUM_DIGITS-1));

   // start fires the cycle after the final guess digit lands, so the
   // scorer sees the complete registered guess.
   mastermind_scorer #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_MAX(DIGIT_MAX)) u_scorer (
      .clk     (CLOCK_50),
      .reset_n (reset_n),
      .start   (start_r),
      .target  (target_r),
      .guess   (guess_r),
      .done    (done_s),
      .exact   (exact_s),
      .part    (part_s)
   );

   // Game FSM and digit registers; set_pulse is checked before alt_pulse
   // so a simultaneous alt_pulse is dropped.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= S_SET_TARGET;
         target_r    <= '0;
         guess_r     <= '0;
         is_random_r <= '0;
         cursor_r    <= '0;
         chances_r   <= CH_W'(MAX_CHANCES);
         exact_cnt_r <= '0;
         part_cnt_r  <= '0;
         start_r     <= 1'b0;
      end else begin
         start_r <= 1'b0;
         case (state_r)
            S_SET_TARGET: begin
               if (accept_s || bus.alt_pulse) begin
                  target_r[cursor_r]    <= accept_s ? bus.sw_val
                                                    : fold_digit(bus.lfsr_val, 4'(DIGIT_MAX));
                  is_random_r[cursor_r] <= !accept_s;
                  if (last_s) begin
                     state_r   <= S_GUESS;
                     cursor_r  <= '0;
                     chances_r <= CH_W'(MAX_CHANCES);
                     guess_r   <= '0;
                  end else begin
                     cursor_r <= cursor_r + CUR_W'(1);
                  end
               end
            end
            S_GUESS: begin
               if (accept_s) begin
                  guess_r[cursor_r] <= bus.sw_val;
                  if (last_s) begin
                     state_r  <= S_SCORE;
                     cursor_r <= '0;
                     start_r  <= 1'b1;
                  end else begin
                     cursor_r <= cursor_r + CUR_W'(1);
                  end
               end else if (bus.alt_pulse && (cursor_r != '0)) begin
                  cursor_r                     <= cursor_r - CUR_W'(1);
                  guess_r[cursor_r - CUR_W'(1)] <= 4'd0;
               end
            end
            S_SCORE: begin
               if (done_s) begin
                  exact_cnt_r <= exact_s;
                  part_cnt_r  <= part_s;
                  if (exact_s == CNT_W'(NUM_DIGITS)) begin
                     state_r <= S_WIN;
                  end else begin
                     chances_r <= chances_r - CH_W'(1);
                     if (chances_r == CH_W'(1)) begin
                        state_r <= S_LOSE;
                     end else begin
                        state_r  <= S_GUESS;
                        cursor_r <= '0;
                        guess_r  <= '0;
                     end
                  end
               end
            end
            S_WIN, S_LOSE: begin
               if (bus.set_pulse) begin
                  state_r     <= S_SET_TARGET;
                  target_r    <= '0;
                  guess_r     <= '0;
                  is_random_r <= '0;
                  cursor_r    <= '0;
                  chances_r   <= CH_W'(MAX_CHANCES);
                  exact_cnt_r <= '0;
                  part_cnt_r  <= '0;
               end
            end
            default: begin
               state_r <= S_SET_TARGET;
            end
         endcase
      end
   end

   // Blink divider: free-running in every state, toggles on each wrap.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_r <= '0;
         blink_r     <= 1'b0;
      end else if (blink_cnt_r == BLK_W'(BLINK_DIV-1)) begin
         blink_cnt_r <= '0;
         blink_r     <= !blink_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + BLK_W'(1);
      end
   end

   assign state     = state_r;
   assign target    = target_r;
   assign guess     = guess_r;
   assign is_random = is_random_r;
   assign cursor    = cursor_r;
   assign chances   = chances_r;
   assign exact_cnt = exact_cnt_r;
   assign part_cnt  = part_cnt_r;
   assign blink_on  = blink_r;
endmodule

// File: tb/tb_mastermind_core.sv
// tb_mastermind_core: scoreboard bench for mastermind_core (4 digits,
// digits 0..9, 5 chances, BLINK_DIV = 4). Expected scores come from a
// greedy pairing model and are queued when the final guess digit is driven.
module tb_mastermind_core;
   import game_types::*;

   localparam int ND = 4;
   localparam int DM = 9;
   localparam int MC = 5;

   logic            clk;
   logic            reset_n;
   state_t          state;
   digit_t [ND-1:0] target;
   digit_t [ND-1:0] guess;
   logic [ND-1:0]   is_random;
   logic [1:0]      cursor;
   logic [2:0]      chances;
   logic [2:0]      exact_cnt;
   logic [2:0]      part_cnt;
   logic            blink_on;

   mastermind_core_if bus ();

   mastermind_core #(.NUM_DIGITS(ND), .DIGIT_MAX(DM), .MAX_CHANCES(MC), .BLINK_DIV(4)) dut (
      .CLOCK_50  (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .state     (state),
      .target    (target),
      .guess     (guess),
      .is_random (is_random),
      .cursor    (cursor),
      .chances   (chances),
      .exact_cnt (exact_cnt),
      .part_cnt  (part_cnt),
      .blink_on  (blink_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int expq[$];
   int tgt_m[ND];
   int gss_m[ND];
   int chances_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag, input bit chk_blink);
      check({tag, ".state"},     32'(state),     32'(S_SET_TARGET));
      check({tag, ".target"},    32'(target),    32'd0);
      check({tag, ".guess"},     32'(guess),     32'd0);
      check({tag, ".is_random"}, 32'(is_random), 32'd0);
      check({tag, ".cursor"},    32'(cursor),    32'd0);
      check({tag, ".chances"},   32'(chances),   32'(MC));
      check({tag, ".exact"},     32'(exact_cnt), 32'd0);
      check({tag, ".part"},      32'(part_cnt),  32'd0);
      if (chk_blink) check({tag, ".blink"}, 32'(blink_on), 32'd0);
   endtask

   task automatic pulse(input bit s, input bit a, input int val, input bit valid, input int lfsr);
      @(negedge clk);
      bus.set_pulse = s;
      bus.alt_pulse = a;
      bus.sw_val    = 4'(val);
      bus.sw_valid  = valid;
      bus.lfsr_val  = 4'(lfsr);
      @(negedge clk);
      bus.set_pulse = 1'b0;
      bus.alt_pulse = 1'b0;
      bus.sw_valid  = 1'b0;
   endtask

   // Greedy pairing: exact positions first, then each remaining guess
   // digit claims one unused, non-exact target digit of the same value.
   task automatic push_expected();
      int  ex;
      int  pt;
      bit  used[ND];
      ex = 0;
      pt = 0;
      for (int i = 0; i < ND; i++) begin
         used[i] = (tgt_m[i] == gss_m[i]);
         if (used[i]) ex++;
      end
      for (int i = 0; i < ND; i++) begin
         if (tgt_m[i] != gss_m[i]) begin
            for (int j = 0; j < ND; j++) begin
               if (!used[j] && tgt_m[j] == gss_m[i]) begin
                  used[j] = 1'b1;
                  pt++;
                  break;
               end
            end
         end
      end
      expq.push_back(ex * 16 + pt);
   endtask

   task automatic wait_score(input bit inject);
      int n;
      int e;
      state_t st_m;
      n = 0;
      while (state == S_SCORE && n < 40) begin
         if (inject && n == 3) begin
            bus.set_pulse = 1'b1;
            bus.alt_pulse = 1'b1;
            bus.sw_valid  = 1'b1;
            bus.sw_val    = 4'd2;
         end
         @(negedge clk);
         bus.set_pulse = 1'b0;
         bus.alt_pulse = 1'b0;
         bus.sw_valid  = 1'b0;
         n++;
      end
      check("score_latency", 32'(n), 32'(DM + 2));
      check("sb_depth", 32'(expq.size()), 32'd1);
      if (expq.size() > 0) begin
         e = expq.pop_front();
         check("exact_cnt", 32'(exact_cnt), 32'(e / 16));
         check("part_cnt",  32'(part_cnt),  32'(e % 16));
         if (e / 16 == ND) begin
            st_m = S_WIN;
         end else begin
            chances_m--;
            st_m = (chances_m == 0) ? S_LOSE : S_GUESS;
         end
         check("post_state",   32'(state),   32'(st_m));
         check("post_chances", 32'(chances), 32'(chances_m));
         if (st_m == S_GUESS) begin
            check("post_cursor", 32'(cursor), 32'd0);
            check("post_guess",  32'(guess),  32'd0);
         end
      end
   endtask

   task automatic set_target_manual(input int a, input int b, input int c, input int d);
      tgt_m = '{a, b, c, d};
      for (int i = 0; i < ND; i++) pulse(1'b1, 1'b0, tgt_m[i], 1'b1, 0);
      chances_m = MC;
   endtask

   task automatic enter_guess(input int a, input int b, input int c, input int d, input bit inject);
      gss_m = '{a, b, c, d};
      for (int i = 0; i < ND - 1; i++) pulse(1'b1, 1'b0, gss_m[i], 1'b1, 0);
      push_expected();
      pulse(1'b1, 1'b0, gss_m[ND-1], 1'b1, 0);
      wait_score(inject);
   endtask

   initial begin
      int n;
      logic b;
      reset_n       = 1'b0;
      bus.set_pulse = 1'b0;
      bus.alt_pulse = 1'b0;
      bus.sw_val    = 4'd0;
      bus.sw_valid  = 1'b0;
      bus.lfsr_val  = 4'd0;
      repeat (3) @(negedge clk);
      check_reset("reset", 1'b1);
      reset_n = 1'b1;

      // blink period
      b = blink_on;
      n = 0;
      while (blink_on == b && n < 20) begin @(negedge clk); n++; end
      b = blink_on;
      n = 0;
      while (blink_on == b && n < 20) begin @(negedge clk); n++; end
      check("blink_period", 32'(n), 32'd4);

      // random target from folded LFSR values
      pulse(1'b0, 1'b1, 0, 1'b0, 12);
      pulse(1'b0, 1'b1, 0, 1'b0, 3);
      pulse(1'b0, 1'b1, 0, 1'b0, 15);
      pulse(1'b0, 1'b1, 0, 1'b0, 9);
      tgt_m     = '{2, 3, 5, 9};
      chances_m = MC;
      check("rand_target",    32'(target),    32'h9532);
      check("rand_is_random", 32'(is_random), 32'hF);
      check("rand_state",     32'(state),     32'(S_GUESS));
      check("rand_chances",   32'(chances),   32'(MC));

      // entry edge cases
      pulse(1'b0, 1'b1, 0, 1'b0, 0);
      check("bksp0_cursor", 32'(cursor), 32'd0);
      pulse(1'b1, 1'b0, 5, 1'b0, 0);
      check("invalid_cursor", 32'(cursor), 32'd0);
      check("invalid_guess",  32'(guess),  32'd0);
      pulse(1'b1, 1'b0, 10, 1'b1, 0);
      check("overrange_cursor", 32'(cursor), 32'd0);
      pulse(1'b1, 1'b0, 7, 1'b1, 0);
      pulse(1'b1, 1'b0, 8, 1'b1, 0);
      check("entry_cursor", 32'(cursor), 32'd2);
      check("entry_guess",  32'(guess),  32'h0087);
      pulse(1'b0, 1'b1, 0, 1'b0, 0);
      check("bksp2_cursor", 32'(cursor), 32'd1);
      check("bksp2_guess",  32'(guess),  32'h0007);
      pulse(1'b1, 1'b1, 4, 1'b1, 0);
      check("both_cursor", 32'(cursor), 32'd2);
      check("both_guess",  32'(guess),  32'h0047);
      pulse(1'b1, 1'b0, 1, 1'b1, 0);
      gss_m = '{7, 4, 1, 6};
      push_expected();
      pulse(1'b1, 1'b0, 6, 1'b1, 0);
      wait_score(1'b0);

      // lose path, one score disturbed by pulses
      enter_guess(9, 2, 3, 5, 1'b1);
      enter_guess(2, 3, 9, 5, 1'b0);
      enter_guess(0, 0, 0, 0, 1'b0);
      enter_guess(2, 3, 5, 8, 1'b0);
      pulse(1'b0, 1'b1, 0, 1'b0, 0);
      check("lose_alt_state", 32'(state), 32'(S_LOSE));
      pulse(1'b1, 1'b0, 0, 1'b0, 0);
      check_reset("after_lose", 1'b0);

      // duplicate scoring
      set_target_manual(1, 1, 2, 3);
      check("man_target",    32'(target),    32'h3211);
      check("man_is_random", 32'(is_random), 32'h0);
      enter_guess(1, 2, 1, 4, 1'b0);

      // reset during cycle 5 of S_SCORE
      for (int i = 0; i < ND; i++) pulse(1'b1, 1'b0, 0, 1'b1, 0);
      check("midscore_state", 32'(state), 32'(S_SCORE));
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset("midscore_reset", 1'b1);
      @(negedge clk);
      reset_n = 1'b1;

      // win on first try
      set_target_manual(4, 0, 7, 7);
      enter_guess(4, 0, 7, 7, 1'b0);
      pulse(1'b0, 1'b1, 0, 1'b0, 0);
      check("win_alt_state", 32'(state), 32'(S_WIN));
      pulse(1'b1, 1'b0, 0, 1'b0, 0);
      check_reset("after_win", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
